register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-port register file for the pipelined multicore datapath. It provides a configurable number of read ports with registered outputs and two write ports with fixed priority. Same-cycle write-to-read bypass is built in. A per-register pending scoreboard lets the decode stage detect RAW hazards on results that are still in flight. It replaces the single-issue two-read/one-write file in each core's decode stage.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 32, number of registers; power of two, at least 2; AW = $clog2(NREGS) is a derived localparam
- RPORTS, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 is hardwired to zero and cannot be reserved

- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- ren  in  RPORTS  per-port read enable
- rsel  in  RPORTS*AW  read addresses; port i is bits [i*AW +: AW]
- rdat  out  RPORTS*DATA_W  registered read data; port i is bits [i*DATA_W +: DATA_W]
- rbusy  out  RPORTS  registered flag; the read register was pending when sampled
- wen  in  2  write enables; bit 1 has priority over bit 0
- wsel  in  2*AW  write addresses
- wdat  in  2*DATA_W  write data
- rsv_en  in  1  reserve request; marks rsv_sel as pending
- rsv_sel  in  AW  register to reserve
- pend  out  NREGS  pending bitmap, registered

## Operation
- **Storage.** NREGS x DATA_W flops.
- **Write.** On the rising edge, each port with wen[k]=1 writes wdat[k] to wsel[k].
  - If both ports target the same register, port 1's data is stored.
  - When ZERO_REG=1, writes to register 0 are dropped.
- **Read.** On the rising edge, each port with ren[i]=1 loads rdat[i] by this priority:
  1. 0, when ZERO_REG=1 and rsel[i]=0.
  2. wdat[1], when wen[1]=1 and wsel[1]=rsel[i] (bypass).
  3. wdat[0], when wen[0]=1 and wsel[0]=rsel[i] (bypass).
  4. The stored value.
- **Read port idle.** When ren[i]=0, rdat[i] and rbusy[i] hold their previous values.
- **Read ports are independent.** All ports may read the same address in the same cycle.
- **rbusy.** rbusy[i] loads the pending bit of rsel[i] after this cycle's write clear, before this cycle's reserve. A register being written this cycle reads as not busy. A register reserved this cycle reads as not busy unless it was already pending.
- **Scoreboard update per edge, applied in order:**
  1. Clear pend[wsel[k]] for every active write port.
  2. Set pend[rsv_sel] if rsv_en=1.
  - The set wins over a same-cycle clear of the same register.
  - Reserving a register that is already pending keeps it pending (no count).
  - With ZERO_REG=1, pend[0] is constantly 0 and reserves of register 0 are ignored.
- **Stray writes.** A write to a non-pending register is legal. It updates data and leaves pend unchanged at 0.

## Timing
- **Reset.** With nRST=0 at a rising edge, the following are all cleared to 0 at that edge:
  - all registers
  - pend
  - rdat
  - rbusy
- **Reset overrides everything.** Reset mid-operation discards same-cycle writes, reads and reserves.
- **Read latency.** 1 cycle: address at edge N yields rdat/rbusy valid after edge N and stable through edge N+1.
- **Write visibility.**
  - Visible to a read sampled at the same edge, via the bypass.
  - Visible to any later read via storage.
- **pend timing.** pend reflects edge-N updates immediately after edge N.
- **No combinational paths.** No output depends combinationally on any input.

## Test plan
- **Reset.** Write 0xDEADBEEF to r5, then hold nRST=0 for one edge. Reading r5 on both ports returns 0, with pend=0 and rbusy=0.
- **Bypass and priority.** In one cycle: wen=2'b11, both wsel=7, wdat0=0x11, wdat1=0x22, ren=2'b11, rsel=7,7. Both rdat ports return 0x22. A read of r7 the next cycle also returns 0x22.
- **Zero register.** Write 0xFFFF to r0, reserve r0, then read r0. Required: rdat=0, pend[0]=0, rbusy=0.
- **Scoreboard round trip.**
  - Reserve r3; the next cycle pend[3]=1, and reading r3 gives rbusy=1.
  - Write r3=0x1234 while reading r3 in the same cycle: rdat=0x1234, rbusy=0, and pend[3]=0 afterwards.
- **Reserve/write collision.** Reserve r9 and write r9=0x55 in the same cycle. Required: pend[9]=1 afterwards and stored r9=0x55.
- **Hold and reset.**
  - Read r4=0xA0 on port 0, then drop ren[0] while writing r4=0xB0. rdat[0] holds 0xA0.
  - Assert nRST=0 mid-sequence with rsv_en=1 on r6: pend[6]=0 afterwards.

Source files
------------

// File: rtl/register_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | register_file_mp: multi-port register file with write bypass and a         |
// | per-register pending scoreboard.                          Rev 1.0          |
// +----------------------------------------------------------------------------+
module register_file_mp #(
  parameter  int DATA_W   = 32,
  parameter  int NREGS    = 32,
  parameter  int RPORTS   = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [RPORTS-1:0]        ren,
  input  logic [RPORTS*AW-1:0]     rsel,
  output logic [RPORTS*DATA_W-1:0] rdat,
  output logic [RPORTS-1:0]        rbusy,
  input  logic [1:0]               wen,
  input  logic [2*AW-1:0]          wsel,
  input  logic [2*DATA_W-1:0]      wdat,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_sel,
  output logic [NREGS-1:0]         pend
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [NREGS-1:0]  r_pend;
  logic [AW-1:0]     w_wsel [2];
  logic [DATA_W-1:0] w_wdat [2];
  logic [1:0]        w_wr_ok;
  logic [NREGS-1:0]  w_pend_cleared;
  logic [NREGS-1:0]  w_pend_next;

  for (genvar k = 0; k < 2; k++) begin : g_wport
    assign w_wsel[k]  = wsel[k*AW +: AW];
    assign w_wdat[k]  = wdat[k*DATA_W +: DATA_W];
    assign w_wr_ok[k] = wen[k] && !((ZERO_REG != 0) && (w_wsel[k] == '0));
  end

  // Port 1 is applied last so it wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++) r_mem[r] <= '0;
    end else begin
      if (w_wr_ok[0]) r_mem[w_wsel[0]] <= w_wdat[0];
      if (w_wr_ok[1]) r_mem[w_wsel[1]] <= w_wdat[1];
    end
  end

  // Clear on write first, then set on reserve, so a same-cycle reserve wins.
  always_comb begin
    w_pend_cleared = r_pend;
    for (int k = 0; k < 2; k++) begin
      if (wen[k]) w_pend_cleared[w_wsel[k]] = 1'b0;
    end
    w_pend_next = w_pend_cleared;
    if (rsv_en) w_pend_next[rsv_sel] = 1'b1;
    if (ZERO_REG != 0) w_pend_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) r_pend <= '0;
    else       r_pend <= w_pend_next;
  end

  assign pend = r_pend;

  for (genvar i = 0; i < RPORTS; i++) begin : g_rport
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_val;
    logic [DATA_W-1:0] r_dat;
    logic              r_busy;

    assign w_addr = rsel[i*AW +: AW];

    always_comb begin
      w_val = r_mem[w_addr];
      if ((ZERO_REG != 0) && (w_addr == '0))     w_val = '0;
      else if (wen[1] && (w_wsel[1] == w_addr)) w_val = w_wdat[1];
      else if (wen[0] && (w_wsel[0] == w_addr)) w_val = w_wdat[0];
    end

    always_ff @(posedge CLK) begin
      if (!nRST) begin
        r_dat  <= '0;
        r_busy <= 1'b0;
      end else if (ren[i]) begin
        r_dat  <= w_val;
        r_busy <= w_pend_cleared[w_addr];
      end
    end

    assign rdat[i*DATA_W +: DATA_W] = r_dat;
    assign rbusy[i]                 = r_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_register_file_mp: directed vector table plus randomized model check.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_register_file_mp;

  logic        CLK;
  logic        nRST;
  logic [1:0]  ren;
  logic [4:0]  rs0, rs1;
  logic [63:0] rdat;
  logic [1:0]  rbusy;
  logic [1:0]  wen;
  logic [4:0]  ws0, ws1;
  logic [31:0] wd0, wd1;
  logic        rsv_en;
  logic [4:0]  rsv_sel;
  logic [31:0] pend;

  int checks   = 0;
  int failures = 0;

  register_file_mp #(
    .DATA_W(32), .NREGS(32), .RPORTS(2), .ZERO_REG(1)
  ) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .ren    (ren),
    .rsel   ({rs1, rs0}),
    .rdat   (rdat),
    .rbusy  (rbusy),
    .wen    (wen),
    .wsel   ({ws1, ws0}),
    .wdat   ({wd1, wd0}),
    .rsv_en (rsv_en),
    .rsv_sel(rsv_sel),
    .pend   (pend)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        nr;
    logic [1:0]  wen;
    logic [4:0]  ws0, ws1;
    logic [31:0] wd0, wd1;
    logic [1:0]  ren;
    logic [4:0]  rs0, rs1;
    logic        rv;
    logic [4:0]  rvs;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic [31:0] ep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic nr, input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] r,
                     input logic [4:0] s0, input logic [4:0] s1, input logic rv, input logic [4:0] rvs,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb,
                     input logic [31:0] ep);
    vec_t v;
    v.nr = nr; v.wen = w; v.ws0 = a0; v.ws1 = a1; v.wd0 = d0; v.wd1 = d1;
    v.ren = r; v.rs0 = s0; v.rs1 = s1; v.rv = rv; v.rvs = rvs;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ep = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic nr, input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] r,
                       input logic [4:0] s0, input logic [4:0] s1, input logic rv, input logic [4:0] rvs);
    nRST = nr; wen = w; ws0 = a0; ws1 = a1; wd0 = d0; wd1 = d1;
    ren = r; rs0 = s0; rs1 = s1; rsv_en = rv; rsv_sel = rvs;
  endtask

  // Reference model state: contents, pending set and last loaded read results.
  logic [31:0] m_mem [32];
  logic        m_pend [32];
  logic [31:0] m_rd [2];
  logic        m_busy [2];

  task automatic model_step();
    logic [4:0] a;
    logic [4:0] rsa [2];
    bit written;
    if (!nRST) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r] = '0;
        m_pend[r] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        m_rd[p] = '0;
        m_busy[p] = 1'b0;
      end
      return;
    end
    rsa[0] = rs0;
    rsa[1] = rs1;
    for (int p = 0; p < 2; p++) begin
      if (ren[p]) begin
        a = rsa[p];
        if (a == 0)                     m_rd[p] = '0;
        else if (wen[1] && ws1 == a)    m_rd[p] = wd1;
        else if (wen[0] && ws0 == a)    m_rd[p] = wd0;
        else                            m_rd[p] = m_mem[a];
        written = (wen[0] && ws0 == a) || (wen[1] && ws1 == a);
        m_busy[p] = m_pend[a] && !written;
      end
    end
    if (wen[0] && ws0 != 0) m_mem[ws0] = wd0;
    if (wen[1] && ws1 != 0) m_mem[ws1] = wd1;
    if (wen[0]) m_pend[ws0] = 1'b0;
    if (wen[1]) m_pend[ws1] = 1'b0;
    if (rsv_en && rsv_sel != 0) m_pend[rsv_sel] = 1'b1;
  endtask

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  initial begin
    drive(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    //   nr wen ws0 ws1 wd0           wd1       ren   rs0 rs1 rv rvs  e0           e1        eb     ep
    add(0, 2'b00, 0, 0, 32'h0,        32'h0,    2'b00, 0, 0, 0, 0,  32'h0,       32'h0,    2'b00, 32'h0);
    add(1, 2'b01, 5, 0, 32'hDEADBEEF, 32'h0,    2'b00, 0, 0, 0, 0,  32'h0,       32'h0,    2'b00, 32'h0);
    add(0, 2'b00, 0, 0, 32'h0,        32'h0,    2'b11, 5, 5, 1, 5,  32'h0,       32'h0,    2'b00, 32'h0);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b11, 5, 5, 0, 0,  32'h0,       32'h0,    2'b00, 32'h0);
    add(1, 2'b11, 7, 7, 32'h11,       32'h22,   2'b11, 7, 7, 0, 0,  32'h22,      32'h22,   2'b00, 32'h0);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b11, 7, 5, 0, 0,  32'h22,      32'h0,    2'b00, 32'h0);
    add(1, 2'b01, 0, 0, 32'hFFFF,     32'h0,    2'b11, 0, 0, 1, 0,  32'h0,       32'h0,    2'b00, 32'h0);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b01, 0, 0, 0, 0,  32'h0,       32'h0,    2'b00, 32'h0);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b00, 0, 0, 1, 3,  32'h0,       32'h0,    2'b00, 32'h8);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b11, 3, 3, 0, 0,  32'h0,       32'h0,    2'b11, 32'h8);
    add(1, 2'b01, 3, 0, 32'h1234,     32'h0,    2'b01, 3, 0, 0, 0,  32'h1234,    32'h0,    2'b10, 32'h0);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b11, 3, 3, 0, 0,  32'h1234,    32'h1234, 2'b00, 32'h0);
    add(1, 2'b10, 0, 9, 32'h0,        32'h55,   2'b00, 0, 0, 1, 9,  32'h1234,    32'h1234, 2'b00, 32'h200);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b11, 9, 9, 0, 0,  32'h55,      32'h55,   2'b11, 32'h200);
    add(1, 2'b01, 4, 0, 32'hA0,       32'h0,    2'b00, 0, 0, 0, 0,  32'h55,      32'h55,   2'b11, 32'h200);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b01, 4, 0, 0, 0,  32'hA0,      32'h55,   2'b10, 32'h200);
    add(1, 2'b01, 4, 0, 32'hB0,       32'h0,    2'b00, 0, 0, 0, 0,  32'hA0,      32'h55,   2'b10, 32'h200);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b01, 4, 0, 0, 0,  32'hB0,      32'h55,   2'b10, 32'h200);
    add(0, 2'b00, 0, 0, 32'h0,        32'h0,    2'b00, 0, 0, 1, 6,  32'h0,       32'h0,    2'b00, 32'h0);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b11, 6, 9, 0, 0,  32'h0,       32'h0,    2'b00, 32'h0);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b01, 2, 0, 1, 2,  32'h0,       32'h0,    2'b00, 32'h4);
    add(1, 2'b00, 0, 0, 32'h0,        32'h0,    2'b01, 2, 0, 1, 2,  32'h0,       32'h0,    2'b01, 32'h4);
    add(1, 2'b10, 0, 12, 32'h0,       32'h77,   2'b10, 0, 12, 0, 0, 32'h0,       32'h77,   2'b01, 32'h4);

    foreach (vecs[n]) begin
      drive(vecs[n].nr, vecs[n].wen, vecs[n].ws0, vecs[n].ws1, vecs[n].wd0, vecs[n].wd1,
            vecs[n].ren, vecs[n].rs0, vecs[n].rs1, vecs[n].rv, vecs[n].rvs);
      @(posedge CLK);
      #1;
      chk("vec_rdat0", n, rdat[31:0], vecs[n].e0);
      chk("vec_rdat1", n, rdat[63:32], vecs[n].e1);
      chk("vec_rbusy", n, {30'd0, rbusy}, {30'd0, vecs[n].eb});
      chk("vec_pend", n, pend, vecs[n].ep);
    end

    // Randomized phase: small address range keeps bypass and hazard cases frequent.
    for (int c = 0; c < 400; c++) begin
      logic [4:0] amax;
      amax = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
      drive((c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0),
            2'($urandom), 5'($urandom_range(0, amax)), 5'($urandom_range(0, amax)),
            $urandom, $urandom, 2'($urandom),
            5'($urandom_range(0, amax)), 5'($urandom_range(0, amax)),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, amax)));
      model_step();
      @(posedge CLK);
      #1;
      chk("rnd_rdat0", c, rdat[31:0], m_rd[0]);
      chk("rnd_rdat1", c, rdat[63:32], m_rd[1]);
      chk("rnd_rbusy", c, {30'd0, rbusy}, {30'd0, m_busy[1], m_busy[0]});
      chk("rnd_pend", c, pend, model_pend_vec());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
